// File: rtl/banked_sp_ram_arb.sv
// Single-clock banked RAM: NUM_BANKS single-port banks shared by ports A and B.
// Same-bank collisions are resolved round-robin; reads return one cycle after grant.

module banked_sp_ram_bank #(
    parameter int DATA_WIDTH = 8,
    parameter int ROW_BITS   = 3
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic [ROW_BITS-1:0]   i_row,
    input  logic [DATA_WIDTH-1:0] i_wdata,
    output logic [DATA_WIDTH-1:0] o_rdata
);
    logic [DATA_WIDTH-1:0] r_mem [2**ROW_BITS];

    always_ff @(posedge clk)
        if (i_we) r_mem[i_row] <= i_wdata;

    // Combinational read; the port-side register provides the one-cycle latency.
    assign o_rdata = r_mem[i_row];
endmodule

module banked_sp_ram_arb #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_BANKS  = 4,
    parameter int INTERLEAVE = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  a_req,
    input  logic                  a_we,
    input  logic [ADDR_WIDTH-1:0] a_addr,
    input  logic [DATA_WIDTH-1:0] a_wdata,
    output logic                  a_gnt,
    output logic                  a_rvalid,
    output logic [DATA_WIDTH-1:0] a_rdata,
    input  logic                  b_req,
    input  logic                  b_we,
    input  logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] b_wdata,
    output logic                  b_gnt,
    output logic                  b_rvalid,
    output logic [DATA_WIDTH-1:0] b_rdata,
    output logic [15:0]           conflict_cnt
);
    localparam int BANK_BITS = $clog2(NUM_BANKS);
    localparam int ROW_BITS  = ADDR_WIDTH - BANK_BITS;

    logic [BANK_BITS-1:0] w_a_bank, w_b_bank;
    logic [ROW_BITS-1:0]  w_a_row,  w_b_row;
    logic                 w_conflict;

    logic [NUM_BANKS-1:0]                 w_bank_we;
    logic [NUM_BANKS-1:0][ROW_BITS-1:0]   w_bank_row;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_wdata;
    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] w_bank_rdata;

    logic                  r_prio;
    logic [15:0]           r_cnt;
    logic                  r_a_rvalid, r_b_rvalid;
    logic [DATA_WIDTH-1:0] r_a_rdata,  r_b_rdata;

    generate
        if (INTERLEAVE != 0) begin : g_interleave
            assign w_a_bank = a_addr[BANK_BITS-1:0];
            assign w_a_row  = a_addr[ADDR_WIDTH-1:BANK_BITS];
            assign w_b_bank = b_addr[BANK_BITS-1:0];
            assign w_b_row  = b_addr[ADDR_WIDTH-1:BANK_BITS];
        end else begin : g_contig
            assign w_a_bank = a_addr[ADDR_WIDTH-1 -: BANK_BITS];
            assign w_a_row  = a_addr[ROW_BITS-1:0];
            assign w_b_bank = b_addr[ADDR_WIDTH-1 -: BANK_BITS];
            assign w_b_row  = b_addr[ROW_BITS-1:0];
        end
    endgenerate

    assign w_conflict = a_req && b_req && (w_a_bank == w_b_bank);

    // On a collision only the prio holder is granted (0 = A, 1 = B).
    assign a_gnt = rst_n && a_req && (!w_conflict || !r_prio);
    assign b_gnt = rst_n && b_req && (!w_conflict ||  r_prio);

    generate
        for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
            logic w_a_sel, w_b_sel;
            assign w_a_sel         = a_gnt && (w_a_bank == BANK_BITS'(g));
            assign w_b_sel         = b_gnt && (w_b_bank == BANK_BITS'(g));
            assign w_bank_we[g]    = (w_a_sel && a_we) || (w_b_sel && b_we);
            assign w_bank_row[g]   = w_a_sel ? w_a_row : w_b_row;
            assign w_bank_wdata[g] = w_a_sel ? a_wdata : b_wdata;

            banked_sp_ram_bank #(
                .DATA_WIDTH(DATA_WIDTH),
                .ROW_BITS  (ROW_BITS)
            ) u_bank (
                .clk    (clk),
                .i_we   (w_bank_we[g]),
                .i_row  (w_bank_row[g]),
                .i_wdata(w_bank_wdata[g]),
                .o_rdata(w_bank_rdata[g])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio     <= 1'b0;
            r_cnt      <= 16'd0;
            r_a_rvalid <= 1'b0;
            r_b_rvalid <= 1'b0;
            r_a_rdata  <= '0;
            r_b_rdata  <= '0;
        end else begin
            if (w_conflict) begin
                r_prio <= ~r_prio;
                if (r_cnt != 16'hFFFF) r_cnt <= r_cnt + 16'd1;
            end
            r_a_rvalid <= a_gnt && !a_we;
            r_b_rvalid <= b_gnt && !b_we;
            // rdata holds its value between reads
            if (a_gnt && !a_we) r_a_rdata <= w_bank_rdata[w_a_bank];
            if (b_gnt && !b_we) r_b_rdata <= w_bank_rdata[w_b_bank];
        end
    end

    assign a_rvalid     = r_a_rvalid;
    assign b_rvalid     = r_b_rvalid;
    assign a_rdata      = r_a_rdata;
    assign b_rdata      = r_b_rdata;
    assign conflict_cnt = r_cnt;
endmodule
